// File: rtl/fp16_pair_packer_if.sv
// Half-in / word-out stream bundle for the fp16 pair packer.
interface fp16_pair_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_keep;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep
    );
endinterface

// File: rtl/fp16_pair_packer.sv
// Packs pairs of fp16 halves into 32-bit words through a small FWFT FIFO.
// Optional FP16_PACK_STATS_EN adds NaN/Inf/subnormal saturating counters.
module fp16_pair_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fp16_pair_packer_if.slave bus,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  nan_cnt,
    output logic [CNT_W-1:0]  inf_cnt,
    output logic [CNT_W-1:0]  sub_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t        state;
    logic [15:0]   hold;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   mem_data [DEPTH];
    logic [1:0]    mem_keep [DEPTH];

    logic        not_full, accept, push, pop;
    logic [31:0] push_data;
    logic [1:0]  push_keep;

    // Latching a low half needs no FIFO space, so IDLE only stalls a flushing half.
    assign not_full     = (count < FULL_LVL);
    assign bus.in_ready = rst_n && ((state == IDLE) ? (!bus.in_last || not_full) : not_full);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && ((state == HOLD) || bus.in_last);
    assign pop          = bus.out_valid && bus.out_ready;

    assign push_data = (state == HOLD) ? {bus.in_data, hold} : {16'h0000, bus.in_data};
    assign push_keep = (state == HOLD) ? 2'b11 : 2'b01;

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = bus.out_valid ? mem_data[rd_ptr] : 32'h0;
    assign bus.out_keep  = bus.out_valid ? mem_keep[rd_ptr] : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            hold   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                if (state == IDLE && !bus.in_last) begin
                    state <= HOLD;
                    hold  <= bus.in_data;
                end else begin
                    state <= IDLE;
                end
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage is not reset; the outputs are masked by count instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_keep[wr_ptr] <= push_keep;
        end
    end

`ifdef FP16_PACK_STATS_EN
    logic [4:0] exp_f;
    logic [9:0] man_f;
    logic       is_nan, is_inf, is_sub;

    assign exp_f  = bus.in_data[14:10];
    assign man_f  = bus.in_data[9:0];
    assign is_nan = (exp_f == 5'h1F) && (man_f != '0);
    assign is_inf = (exp_f == 5'h1F) && (man_f == '0);
    assign is_sub = (exp_f == 5'h00) && (man_f != '0);

    // A clear still records a hit landing in the same cycle.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic hit, input logic clr);
        if (clr) return CNT_W'(hit);
        if (hit && (cnt != '1)) return cnt + CNT_W'(1);
        return cnt;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
            sub_cnt <= '0;
        end else begin
            nan_cnt <= cnt_next(nan_cnt, accept && is_nan, clr_cnt);
            inf_cnt <= cnt_next(inf_cnt, accept && is_inf, clr_cnt);
            sub_cnt <= cnt_next(sub_cnt, accept && is_sub, clr_cnt);
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign nan_cnt    = '0;
    assign inf_cnt    = '0;
    assign sub_cnt    = '0;
`endif
endmodule

// File: tb/tb_fp16_pair_packer.sv
// Directed bench for fp16_pair_packer with a word scoreboard and a bench-side packing model.
module tb_fp16_pair_packer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_cnt = 1'b0;
    logic [CNT_W-1:0] nan_cnt, inf_cnt, sub_cnt;

    fp16_pair_packer_if bus ();

    fp16_pair_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_cnt(clr_cnt),
        .nan_cnt(nan_cnt), .inf_cnt(inf_cnt), .sub_cnt(sub_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [33:0] sb [$];      // {keep, data}
    bit          mh_valid = 1'b0;
    logic [15:0] mh_data = '0;
    int          en = 0, ei = 0, es = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef FP16_PACK_STATS_EN
        chk({tag, "_nan"}, 32'(nan_cnt), 32'(en));
        chk({tag, "_inf"}, 32'(inf_cnt), 32'(ei));
        chk({tag, "_sub"}, 32'(sub_cnt), 32'(es));
`else
        chk({tag, "_nan"}, 32'(nan_cnt), 32'd0);
        chk({tag, "_inf"}, 32'(inf_cnt), 32'd0);
        chk({tag, "_sub"}, 32'(sub_cnt), 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one half until accepted; in_ready is checked against the model every cycle.
    task automatic send(input logic [15:0] d, input bit last);
        bit accepted = 1'b0;
        bit exp_rdy;
        bit hn, hi, hs;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        #1;
        for (int n = 0; n < 50 && !accepted; n++) begin
            exp_rdy = mh_valid ? (sb.size() < DEPTH) : (!last || sb.size() < DEPTH);
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (bus.in_ready) begin
                accepted = 1'b1;
                hn = (d[14:10] == 5'h1F) && (d[9:0] != 0);
                hi = (d[14:10] == 5'h1F) && (d[9:0] == 0);
                hs = (d[14:10] == 5'h00) && (d[9:0] != 0);
                if (clr_cnt) begin
                    en = int'(hn); ei = int'(hi); es = int'(hs);
                end else begin
                    en += int'(hn); ei += int'(hi); es += int'(hs);
                end
                if (mh_valid) begin
                    sb.push_back({2'b11, d, mh_data});
                    mh_valid = 1'b0;
                end else if (last) begin
                    sb.push_back({2'b01, 16'h0000, d});
                end else begin
                    mh_valid = 1'b1;
                    mh_data  = d;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", 32'(accepted), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: compare each popped word against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", bus.out_data, 32'hDEAD_BEEF);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                chk("out_data", bus.out_data, e[31:0]);
                chk("out_keep", 32'(bus.out_keep), 32'(e[33:32]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_keep", 32'(bus.out_keep), 32'd0);
        chk_cnt("rst");
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic pair, latency of one edge
        send(16'h3C00, 1'b0);
        chk("pair_no_word_yet", 32'(bus.out_valid), 32'd0);
        send(16'hC000, 1'b0);
        chk("pair_out_valid", 32'(bus.out_valid), 32'd1);
        chk("pair_out_data", bus.out_data, 32'hC000_3C00);
        chk("pair_out_keep", 32'(bus.out_keep), 32'd3);
        tick(); tick();

        // Lone half flushed by in_last
        send(16'h7C00, 1'b1);
        chk("flush_out_data", bus.out_data, 32'h0000_7C00);
        chk("flush_out_keep", 32'(bus.out_keep), 32'd1);
        chk_cnt("flush");
        tick(); tick();

        // Fill FIFO with out_ready low, ninth half parks in HOLD
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 2 * DEPTH + 1; i++) send(16'(i), 1'b0);
        chk("full_head", bus.out_data, 32'h0002_0001);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd10;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_stall_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        // Release: one pop, then push and pop on the same edge
        bus.out_ready = 1'b1;
        send(16'd10, 1'b0);
        chk("simul_out_valid", 32'(bus.out_valid), 32'd1);
        drain();
        tick();
        chk("drained_out_valid", 32'(bus.out_valid), 32'd0);

        // Classification counters
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        en = 0; ei = 0; es = 0;
        chk_cnt("clr_idle");
        send(16'h7E00, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h7C01, 1'b0);
        chk_cnt("classify");
`ifdef FP16_PACK_STATS_EN
        chk("classify_nan_const", 32'(nan_cnt), 32'd2);
        chk("classify_sub_const", 32'(sub_cnt), 32'd1);
        chk("classify_inf_const", 32'(inf_cnt), 32'd0);
`endif
        clr_cnt = 1'b1;
        send(16'h7E00, 1'b0);
        clr_cnt = 1'b0;
        chk_cnt("clr_hit");
        send(16'h0000, 1'b1);
        drain();

        // Reset mid-operation drops queued words and the held half
        bus.out_ready = 1'b0;
        for (int i = 11; i <= 15; i++) send(16'(i), 1'b0);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        mh_valid = 1'b0;
        en = 0; ei = 0; es = 0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_data", bus.out_data, 32'd0);
        chk("midrst_out_keep", 32'(bus.out_keep), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk_cnt("midrst");
        bus.out_ready = 1'b1;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        chk("post_rst_word", bus.out_data, 32'h0002_0001);
        drain();
        tick(); tick(); tick();
        chk("final_out_valid", 32'(bus.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
